// File: rtl/spike_rate_decoder_pkg.sv
// Shared types, default widths and the saturating-increment helper
// used across the spike rate decoder.
package spike_decoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int unsigned DEF_WIN_W = 8;
  localparam int unsigned DEF_CNT_W = 8;
  localparam int unsigned DEF_ISI_W = 8;

  // Increment v by one, clamping at the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Result port of the decoder: rate/ISI payload with a valid/ready
// handshake plus the sticky overrun flag.
interface spike_rate_decoder_if
  import spike_decoder_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned ISI_W = DEF_ISI_W
);
  logic [CNT_W-1:0] rate;
  logic [ISI_W-1:0] last_isi;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;

  modport master (
    output rate, last_isi, out_valid, overrun,
    input  out_ready
  );

  modport slave (
    input  rate, last_isi, out_valid, overrun,
    output out_ready
  );
endinterface

// File: rtl/spike_rate_decoder_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
  import spike_decoder_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= W'(sat_inc(32'(value), W));
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts spikes per window, tracks the latest
// inter-spike interval and presents each window result on a valid/ready port.
module spike_rate_decoder
  import spike_decoder_pkg::*;
#(
  parameter int unsigned WIN_W = DEF_WIN_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned ISI_W = DEF_ISI_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic                  spike,
  input  logic [WIN_W-1:0]      window_len,
  spike_rate_decoder_if.master  res
);

  state_t state, state_next;

  logic [WIN_W-1:0] win_reg, cyc_cnt;
  logic [CNT_W-1:0] spk_cnt, spk_final, rate;
  logic [ISI_W-1:0] isi_cnt, isi_reg, isi_next, last_isi;
  logic             seen_spike, out_valid, overrun;
  logic             in_count, complete, load, cnt_clr, isi_clr;

  assign in_count = (state == COUNT);
  assign complete = in_count && (cyc_cnt == win_reg - WIN_W'(1));
  assign load     = complete && !clear && (!out_valid || res.out_ready);

  // Window counters also clear on completion: the completing cycle's spike
  // goes into spk_final, not into the next window.
  assign cnt_clr  = clear || !in_count || !enable || complete;
  assign isi_clr  = clear || !in_count || !enable || spike;

  assign spk_final = spike ? CNT_W'(sat_inc(32'(spk_cnt), CNT_W)) : spk_cnt;

  always_comb begin
    isi_next = isi_reg;
    if (in_count && spike) begin
      isi_next = seen_spike ? ISI_W'(sat_inc(32'(isi_cnt), ISI_W)) : '0;
    end
  end

  sat_counter #(.W(WIN_W)) u_cyc (
    .clk(clk), .rst(rst), .inc(in_count), .clr(cnt_clr), .value(cyc_cnt)
  );

  sat_counter #(.W(CNT_W)) u_spk (
    .clk(clk), .rst(rst), .inc(in_count && spike), .clr(cnt_clr), .value(spk_cnt)
  );

  sat_counter #(.W(ISI_W)) u_isi (
    .clk(clk), .rst(rst), .inc(in_count), .clr(isi_clr), .value(isi_cnt)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable)  state_next = COUNT;
      COUNT:   if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      win_reg    <= '0;
      seen_spike <= 1'b0;
      isi_reg    <= '0;
    end else begin
      state <= state_next;
      if (enable && !clear && (!in_count || complete)) begin
        win_reg <= (window_len == '0) ? WIN_W'(1) : window_len;
      end
      if (clear || !in_count || !enable) begin
        seen_spike <= 1'b0;
      end else if (spike) begin
        seen_spike <= 1'b1;
      end
      if (!clear) begin
        isi_reg <= isi_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate      <= '0;
      last_isi  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (load) begin
      rate      <= spk_final;
      last_isi  <= isi_next;
      out_valid <= 1'b1;
    end else if (complete) begin
      overrun   <= 1'b1;
    end else if (out_valid && res.out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign res.rate      = rate;
  assign res.last_isi  = last_isi;
  assign res.out_valid = out_valid;
  assign res.overrun   = overrun;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a timestamp-based window model is
// compared against the DUT every cycle, plus literal checks per scenario.
module tb_spike_rate_decoder;
  import spike_decoder_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic       spike = 1'b0;
  logic [7:0] window_len = '0;
  bit         chk_en = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  spike_rate_decoder_if #(.CNT_W(8), .ISI_W(8)) bus ();

  spike_rate_decoder #(.WIN_W(8), .CNT_W(8), .ISI_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .spike(spike),
    .window_len(window_len), .res(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: windows tracked by position/length, ISI from spike timestamps.
  bit     m_active, m_seen, m_valid, m_ovr;
  int     m_len, m_pos, m_cnt, m_isi, m_rate, m_lisi;
  longint cyc, m_last_t;

  always @(posedge clk or posedge rst) begin : model
    bit done;
    int res_rate, res_isi;
    if (rst) begin
      m_active = 0; m_seen = 0; m_valid = 0; m_ovr = 0;
      m_len = 0; m_pos = 0; m_cnt = 0; m_isi = 0; m_rate = 0; m_lisi = 0;
      cyc = 0; m_last_t = 0;
    end else begin
      cyc++;
      done = 0; res_rate = 0; res_isi = 0;
      if (clear) begin
        m_valid = 0; m_ovr = 0; m_active = 0; m_seen = 0;
      end else begin
        if (m_active) begin
          if (spike) begin
            m_cnt++;
            if (m_seen) m_isi = ((cyc - m_last_t) > 255) ? 255 : int'(cyc - m_last_t);
            else        m_isi = 0;
            m_seen = 1;
            m_last_t = cyc;
          end
          m_pos++;
          if (m_pos == m_len) begin
            done = 1;
            res_rate = (m_cnt > 255) ? 255 : m_cnt;
            res_isi = m_isi;
            if (enable) begin
              m_len = (window_len == 0) ? 1 : int'(window_len);
              m_pos = 0; m_cnt = 0;
            end else begin
              m_active = 0; m_seen = 0;
            end
          end else if (!enable) begin
            m_active = 0; m_seen = 0;
          end
        end else if (enable) begin
          m_active = 1;
          m_len = (window_len == 0) ? 1 : int'(window_len);
          m_pos = 0; m_cnt = 0;
        end
        if (done) begin
          if (!m_valid || bus.out_ready) begin
            m_valid = 1; m_rate = res_rate; m_lisi = res_isi;
          end else begin
            m_ovr = 1;
          end
        end else if (m_valid && bus.out_ready) begin
          m_valid = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("model_rate",    bus.rate,      m_rate);
      chk("model_isi",     bus.last_isi,  m_lisi);
      chk("model_valid",   bus.out_valid, m_valid);
      chk("model_overrun", bus.overrun,   m_ovr);
    end
  end

  task automatic cyc_step(input bit en, input bit spk);
    enable = en;
    spike  = spk;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_rate", bus.rate, 0);
    chk("reset_isi", bus.last_isi, 0);
    chk("reset_valid", bus.out_valid, 0);
    chk("reset_overrun", bus.overrun, 0);
    chk("reset_state", dut.state, IDLE);
    chk_en = 1'b1;

    // basic count: spikes on window cycles 2, 5, 9
    window_len = 8'd10;
    bus.out_ready = 1'b1;
    cyc_step(1, 0);
    for (int k = 0; k < 10; k++) cyc_step(k != 9, (k == 2) || (k == 5) || (k == 9));
    chk("basic_valid", bus.out_valid, 1);
    chk("basic_rate", bus.rate, 3);
    chk("basic_isi", bus.last_isi, 4);
    cyc_step(0, 0);
    chk("basic_pulse_once", bus.out_valid, 0);

    // saturation of count and of ISI
    window_len = 8'd255;
    cyc_step(1, 1);
    for (int k = 0; k < 255; k++) cyc_step(k != 254, 1);
    chk("sat_rate", bus.rate, 255);
    chk("sat_isi", bus.last_isi, 1);
    cyc_step(0, 0);
    window_len = 8'd200;
    cyc_step(1, 0);
    for (int t = 0; t < 400; t++) cyc_step(t != 399, (t == 0) || (t == 360));
    chk("gap_rate", bus.rate, 1);
    chk("gap_isi", bus.last_isi, 255);
    cyc_step(0, 0);

    // back-to-back windows under backpressure
    bus.out_ready = 1'b0;
    window_len = 8'd4;
    cyc_step(1, 0);
    for (int t = 0; t < 16; t++) begin
      if (t == 15) bus.out_ready = 1'b1;
      cyc_step(t != 15, (t % 4) <= (t / 4));
      if (t == 3) begin
        chk("bp_first_valid", bus.out_valid, 1);
        chk("bp_first_rate", bus.rate, 1);
        chk("bp_first_overrun", bus.overrun, 0);
      end
      if (t == 7) begin
        chk("bp_hold_rate", bus.rate, 1);
        chk("bp_overrun_set", bus.overrun, 1);
      end
      if (t == 11) chk("bp_hold2_rate", bus.rate, 1);
    end
    bus.out_ready = 1'b0;
    chk("bp_load_rate", bus.rate, 4);
    chk("bp_load_isi", bus.last_isi, 1);
    chk("bp_load_overrun", bus.overrun, 1);

    // soft clear with valid and overrun both set
    clear = 1'b1;
    cyc_step(0, 0);
    clear = 1'b0;
    chk("clr_valid", bus.out_valid, 0);
    chk("clr_overrun", bus.overrun, 0);
    chk("clr_rate_kept", bus.rate, 4);
    chk("clr_isi_kept", bus.last_isi, 1);

    // abort mid-window, then a fresh window (window_len change mid-window ignored)
    bus.out_ready = 1'b1;
    window_len = 8'd10;
    cyc_step(1, 0);
    for (int k = 0; k < 5; k++) cyc_step(1, (k == 1) || (k == 3));
    cyc_step(0, 0);
    chk("abort_idle", dut.state, IDLE);
    chk("abort_no_valid", bus.out_valid, 0);
    repeat (3) cyc_step(0, 0);
    window_len = 8'd6;
    cyc_step(1, 0);
    for (int k = 0; k < 6; k++) begin
      if (k == 2) window_len = 8'd20;
      cyc_step(k != 5, k == 3);
    end
    chk("fresh_valid", bus.out_valid, 1);
    chk("fresh_rate", bus.rate, 1);
    chk("fresh_isi", bus.last_isi, 0);
    cyc_step(0, 0);

    // zero length behaves as one-cycle windows
    window_len = 8'd0;
    cyc_step(1, 1);
    for (int k = 0; k < 5; k++) begin
      cyc_step(k != 4, 1);
      chk("zl_valid", bus.out_valid, 1);
      chk("zl_rate", bus.rate, 1);
      chk("zl_isi", bus.last_isi, (k == 0) ? 0 : 1);
    end
    cyc_step(0, 0);

    // asynchronous reset mid-window with a held result and overrun
    bus.out_ready = 1'b0;
    window_len = 8'd3;
    cyc_step(1, 0);
    for (int k = 0; k < 7; k++) cyc_step(1, 1);
    chk("prerst_valid", bus.out_valid, 1);
    chk("prerst_overrun", bus.overrun, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_rate", bus.rate, 0);
    chk("arst_isi", bus.last_isi, 0);
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_overrun", bus.overrun, 0);
    chk("arst_state", dut.state, IDLE);
    enable = 1'b0;
    spike = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
